// File: rtl/pkt_acc_pkg.sv
// Shared types for the packet accumulator: the two-state handshake FSM encoding.
package pkt_acc_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

endpackage

// File: rtl/pkt_acc.sv
// Packet accumulator: sums and counts the beats of a packet, then holds the result
// for the downstream handshake before accepting the next packet.
module pkt_acc
  import pkt_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [SUM_WIDTH-1:0]  o_sum,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  output logic                  o_ovf
);

  state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept_s;
  logic [SUM_WIDTH:0]   add_s;
  logic                 cnt_full_s;

  // Extra top bit of the adder captures the carry out of the accumulator.
  assign accept_s   = i_vld && (state_q == ACC);
  assign add_s      = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - DATA_WIDTH){1'b0}}, i_data};
  assign cnt_full_s = &cnt_q;

  // Next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (accept_s) begin
          sum_d   = add_s[SUM_WIDTH-1:0];
          cnt_d   = cnt_full_s ? cnt_q : cnt_q + CNT_WIDTH'(1'b1);
          ovf_d   = ovf_q | add_s[SUM_WIDTH] | cnt_full_s;
          state_d = i_last ? OUT : ACC;
        end else begin
          state_d = ACC;
        end
      end
      OUT: begin
        if (i_rdy) begin
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State and accumulator registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs depend only on the state register.
  assign o_rdy = (state_q == ACC);
  assign o_vld = (state_q == OUT);
  assign o_sum = sum_q;
  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_pkt_acc.sv
// Scoreboard bench: three pkt_acc instances (default, 16-bit sum, 2-bit count) share stimulus.
module tb_pkt_acc;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vld;
  logic [15:0] i_data;
  logic        i_last;
  logic        i_rdy;
  logic        rdy_dir;
  logic        rnd_mode;
  logic        rnd_rdy;

  logic        o_rdy0, o_vld0, o_ovf0;
  logic [31:0] o_sum0;
  logic [7:0]  o_cnt0;
  logic        o_rdy1, o_vld1, o_ovf1;
  logic [15:0] o_sum1;
  logic [7:0]  o_cnt1;
  logic        o_rdy2, o_vld2, o_ovf2;
  logic [31:0] o_sum2;
  logic [1:0]  o_cnt2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q [3][$];

  always #5 clk = ~clk;

  assign i_rdy = rnd_mode ? rnd_rdy : rdy_dir;

  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  pkt_acc dut0 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy0), .i_data(i_data),
    .i_last(i_last), .o_vld(o_vld0), .i_rdy(i_rdy), .o_sum(o_sum0), .o_cnt(o_cnt0),
    .o_ovf(o_ovf0)
  );

  pkt_acc #(.DATA_WIDTH(16), .SUM_WIDTH(16), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy1), .i_data(i_data),
    .i_last(i_last), .o_vld(o_vld1), .i_rdy(i_rdy), .o_sum(o_sum1), .o_cnt(o_cnt1),
    .o_ovf(o_ovf1)
  );

  pkt_acc #(.DATA_WIDTH(16), .SUM_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy2), .i_data(i_data),
    .i_last(i_last), .o_vld(o_vld2), .i_rdy(i_rdy), .o_sum(o_sum2), .o_cnt(o_cnt2),
    .o_ovf(o_ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [31:0] sum, input logic [7:0] cnt,
                      input logic ovf);
    exp_t e;
    e.sum = sum;
    e.cnt = cnt;
    e.ovf = ovf;
    exp_q[id].push_back(e);
  endtask

  task automatic push3(input logic [31:0] sum, input logic [7:0] cnt, input logic ovf);
    for (int k = 0; k < 3; k++) push(k, sum, cnt, ovf);
  endtask

  // Compare the presented result against the queue head; pop on handshake.
  task automatic mon(input int id, input logic vld, input logic rdy, input logic [31:0] sum,
                     input logic [7:0] cnt, input logic ovf);
    exp_t e;
    chk($sformatf("rdy_excl%0d", id), {63'd0, rdy}, {63'd0, !vld});
    if (vld) begin
      if (exp_q[id].size() == 0) begin
        chk($sformatf("unexpected_result%0d", id), {32'd0, sum}, 64'd0 - 64'd1);
      end else begin
        e = exp_q[id][0];
        chk($sformatf("sum%0d", id), {32'd0, sum}, {32'd0, e.sum});
        chk($sformatf("cnt%0d", id), {56'd0, cnt}, {56'd0, e.cnt});
        chk($sformatf("ovf%0d", id), {63'd0, ovf}, {63'd0, e.ovf});
        if (i_rdy) void'(exp_q[id].pop_front());
      end
    end
  endtask

  always @(negedge clk) if (rst_n) mon(0, o_vld0, o_rdy0, o_sum0, o_cnt0, o_ovf0);
  always @(negedge clk) if (rst_n) mon(1, o_vld1, o_rdy1, {16'd0, o_sum1}, o_cnt1, o_ovf1);
  always @(negedge clk) if (rst_n) mon(2, o_vld2, o_rdy2, o_sum2, {6'd0, o_cnt2}, o_ovf2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    int n = 0;
    i_vld  = 1'b1;
    i_data = d;
    i_last = last;
    while (!o_rdy0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("beat_wait_timeout", 64'(n), 64'd0);
    tick();
    i_vld  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] tot;
    logic [15:0] d;
    int          n;
    int          w;
    rst_n    = 1'b0;
    i_vld    = 1'b0;
    i_data   = 16'd0;
    i_last   = 1'b0;
    rdy_dir  = 1'b1;
    rnd_mode = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_vld", {63'd0, o_vld0}, 64'd0);
    chk("rst_rdy", {63'd0, o_rdy0}, 64'd1);
    chk("rst_sum", {32'd0, o_sum0}, 64'd0);
    chk("rst_cnt", {56'd0, o_cnt0}, 64'd0);
    chk("rst_ovf", {63'd0, o_ovf2}, 64'd0);

    // 5,6,7 with an ignored junk cycle in between
    push3(32'd18, 8'd3, 1'b0);
    beat(16'd5, 1'b0);
    i_data = 16'hAAAA;
    i_last = 1'b1;
    tick();
    i_last = 1'b0;
    beat(16'd6, 1'b0);
    beat(16'd7, 1'b1);
    chk("lat_vld", {63'd0, o_vld0}, 64'd1);
    tick();
    chk("rel_vld", {63'd0, o_vld0}, 64'd0);
    chk("rel_rdy", {63'd0, o_rdy0}, 64'd1);

    // Single beat held for four cycles
    rdy_dir = 1'b0;
    push3(32'h0000FFFF, 8'd1, 1'b0);
    beat(16'hFFFF, 1'b1);
    chk("hold_vld0", {63'd0, o_vld0}, 64'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("hold_vld%0d", k), {63'd0, o_vld0}, 64'd1);
    end
    rdy_dir = 1'b1;
    tick();
    chk("hold_rel_vld", {63'd0, o_vld0}, 64'd0);
    chk("hold_rel_rdy", {63'd0, o_rdy0}, 64'd1);

    // Sum wrap on the 16-bit instance, then a clean packet
    push(0, 32'h00010001, 8'd2, 1'b0);
    push(1, 32'h00000001, 8'd2, 1'b1);
    push(2, 32'h00010001, 8'd2, 1'b0);
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
    push3(32'd1, 8'd1, 1'b0);
    beat(16'd1, 1'b1);

    // Five beats of 1: count saturates on the 2-bit instance
    push(0, 32'd5, 8'd5, 1'b0);
    push(1, 32'd5, 8'd5, 1'b0);
    push(2, 32'd5, 8'd3, 1'b1);
    for (int k = 0; k < 4; k++) beat(16'd1, 1'b0);
    beat(16'd1, 1'b1);

    // Reset mid-packet discards beats 1,2
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    do_reset();
    chk("midrst_sum", {32'd0, o_sum0}, 64'd0);
    chk("midrst_cnt", {56'd0, o_cnt0}, 64'd0);
    push3(32'd4, 8'd1, 1'b0);
    beat(16'd4, 1'b1);
    tick();

    // Reset while a result is pending drops it
    rdy_dir = 1'b0;
    push3(32'd9, 8'd1, 1'b0);
    beat(16'd9, 1'b1);
    tick();
    do_reset();
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    chk("outrst_vld", {63'd0, o_vld0}, 64'd0);
    chk("outrst_rdy", {63'd0, o_rdy0}, 64'd1);
    rdy_dir = 1'b1;

    // Random valid/ready traffic
    rnd_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      n   = $urandom_range(1, 6);
      tot = 64'd0;
      for (int b = 0; b < n; b++) begin
        d   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
        tot = tot + {48'd0, d};
        if (b == 0) begin
          // expectation computed once the whole packet is known, so stash data first
        end
      end
      // regenerate deterministically is impossible; instead send recorded beats
      p = p;
      begin
        logic [15:0] beats [6];
        logic [63:0] t2;
        t2 = 64'd0;
        for (int b = 0; b < n; b++) begin
          beats[b] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
          t2 = t2 + {48'd0, beats[b]};
        end
        push(0, t2[31:0], 8'(n), 1'b0);
        push(1, {16'd0, t2[15:0]}, 8'(n), t2 >= 64'd65536);
        push(2, t2[31:0], (n > 3) ? 8'd3 : 8'(n), n > 3);
        for (int b = 0; b < n; b++) begin
          w = $urandom_range(0, 2);
          for (int g = 0; g < w; g++) begin
            i_vld  = 1'b0;
            i_data = 16'($urandom);
            i_last = 1'($urandom);
            tick();
          end
          beat(beats[b], b == n - 1);
        end
      end
    end
    rnd_mode = 1'b0;
    rdy_dir  = 1'b1;
    w = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 100) begin
      tick();
      w++;
    end
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("drain%0d", k), 64'(exp_q[k].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
